ifu_fetch_ctrl: RTL and testbench
=================================

// Module: ifu_fetch_ctrl
// PURPOSE
//  Fetch sequencer owning the program counter. Issues one instruction-memory request per PC,
//  holds the returned instruction for decode under valid/ready, and applies redirects
//  (trap, mret, branch/jump) with fixed priority. Redirects kill any stale in-flight fetch.
//  Sits between the IFU memory port and IDU; replaces the free-running pc+4 register.
// PARAMETERS
//  XLEN      64            PC / address width (matches `RegWidth)
//  PC_RST    64'h80000000  PC loaded on reset (matches `PcRst)
//  ILEN      32            instruction width
// PORTS
//  clk             in   1     core clock
//  rst             in   1     asynchronous reset, active-high
//  imem_req_valid  out  1     fetch request valid
//  imem_req_ready  in   1     imem accepts request
//  imem_req_addr   out  XLEN  fetch address, stable while valid && !ready
//  imem_rsp_valid  in   1     instruction data valid (1-cycle pulse, in-order, one per request)
//  imem_rsp_data   in   ILEN  instruction word
//  inst_valid      out  1     instruction available to decode
//  inst_ready      in   1     decode consumes instruction
//  inst            out  ILEN  held instruction
//  inst_pc         out  XLEN  PC of held instruction
//  br_valid        in   1     branch taken / jump (pulse)
//  br_target       in   XLEN  branch/jump target
//  mret_valid      in   1     mret retire (pulse)
//  mepc            in   XLEN  return address
//  trap_valid      in   1     exception/interrupt (pulse)
//  trap_vec        in   XLEN  mtvec-derived handler address
//  current_pc      out  XLEN  architectural fetch PC
// BEHAVIOUR
//  - Reset (async): state=REQ, pc=PC_RST, kill=0, pend=0; inst_valid=0, inst=0, inst_pc=0.
//    imem_req_valid=1 in the first cycle after reset deassertion, addr=PC_RST.
//  - FSM: REQ  : req_valid=1, addr=pc. On ready -> WAIT.
//         WAIT : on rsp_valid: kill=1 -> clear kill, REQ; kill=0 -> capture data, pc into
//                inst/inst_pc, -> OUT.
//         OUT  : inst_valid=1, inst/inst_pc stable. On inst_ready: pc=pc+4 -> REQ.
//  - Redirect target sel (same cycle, priority): trap_vec > mepc > br_target; any of the
//    three valid = redirect. Lower-priority simultaneous redirects are dropped.
//  - Redirect in OUT: inst dropped (inst_valid=0 next cycle), pc=target, -> REQ. Redirect
//    wins over a same-cycle inst_ready (no pc+4).
//  - Redirect in WAIT: pc=target, kill=1; response, when it arrives, is discarded. If
//    rsp_valid arrives same cycle as redirect, it is discarded, -> REQ directly, kill stays 0.
//  - Redirect in REQ with ready=1: pc=target, kill=1, -> WAIT.
//  - Redirect in REQ with ready=0: addr must not change; target latched in pend_pc, pend=1.
//    On acceptance: pc=pend_pc, pend=0, kill=1, -> WAIT. Newer redirect overwrites pend_pc.
//  - Arithmetic: pc+4 modulo 2^XLEN (wraps silently). No alignment check here; low 2 target
//    bits passed through unchanged (misalignment trapped by EXU).
//  - Latency: REQ->OUT minimum 2 cycles (ready=1, rsp next cycle); 1 instruction per 3 cycles
//    best case. current_pc = pc register (redirect visible next cycle).
//  - Reset mid-operation: all state cleared immediately; imem shares rst, so no stale
//    response survives.
// STRUCTURE
//  - Shared defines: XLEN, ILEN, PC_RST, FSM state encoding (2-bit REQ/WAIT/OUT),
//    redirect-cause encoding {NONE,BR,MRET,TRAP}.
//  - Sub-module: ifu_redirect_mux (combinational priority select -> redir_valid,
//    redir_target, redir_cause). PC, pend, kill and FSM registers live in the top.
// TESTING
//  - Reset release, imem ready=1, rsp 1 cycle later, decode ready=1 -> addrs 0x80000000,
//    0x80000004, 0x80000008 issued 3 cycles apart; inst_pc matches.
//  - Decode back-pressure: inst_ready=0 for 5 cycles in OUT -> inst/inst_pc stable, no new
//    request, pc unchanged; ready=1 -> next addr pc+4.
//  - br_valid target 0x80000100 in WAIT -> next rsp discarded (inst_valid stays 0), next req
//    addr 0x80000100.
//  - trap_valid+mret_valid+br_valid same cycle in OUT, trap_vec 0x80000800 -> next req addr
//    0x80000800; inst_ready in that cycle ignored.
//  - Redirect in REQ with ready=0 for 3 cycles -> addr stable at old pc; on accept, response
//    killed, next req addr = latched target.
//  - pc 0xFFFFFFFFFFFFFFFC, handshake -> next addr 0x0; async rst mid-WAIT -> outputs reset
//    without clk edge, first req addr PC_RST.

Source files
------------

// File: rtl/ifu_fetch_ctrl_pkg.sv
// Shared widths, reset PC, FSM/redirect encodings and payload types for the fetch sequencer.
package ifu_fetch_ctrl_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  localparam logic [XLEN-1:0] PC_RST     = 64'h0000_0000_8000_0000;
  localparam logic [XLEN-1:0] INST_BYTES = XLEN'(4);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_OUT  = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    REDIR_NONE = 2'd0,
    REDIR_BR   = 2'd1,
    REDIR_MRET = 2'd2,
    REDIR_TRAP = 2'd3
  } redir_cause_e;

  // Instruction held for decode together with the PC it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] word;
  } fetch_inst_t;

  // Sequential successor; wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] next_seq_pc(input logic [XLEN-1:0] pc);
    return pc + INST_BYTES;
  endfunction

endpackage

// File: rtl/ifu_fetch_ctrl_if.sv
// Fetch controller bus: imem request/response, decode hand-off, redirect inputs, PC view.
interface ifu_fetch_ctrl_if;

  logic                                 imem_req_valid;
  logic                                 imem_req_ready;
  logic [ifu_fetch_ctrl_pkg::XLEN-1:0]  imem_req_addr;
  logic                                 imem_rsp_valid;
  logic [ifu_fetch_ctrl_pkg::ILEN-1:0]  imem_rsp_data;

  logic                                 inst_valid;
  logic                                 inst_ready;
  logic [ifu_fetch_ctrl_pkg::ILEN-1:0]  inst;
  logic [ifu_fetch_ctrl_pkg::XLEN-1:0]  inst_pc;

  logic                                 br_valid;
  logic [ifu_fetch_ctrl_pkg::XLEN-1:0]  br_target;
  logic                                 mret_valid;
  logic [ifu_fetch_ctrl_pkg::XLEN-1:0]  mepc;
  logic                                 trap_valid;
  logic [ifu_fetch_ctrl_pkg::XLEN-1:0]  trap_vec;

  logic [ifu_fetch_ctrl_pkg::XLEN-1:0]  current_pc;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, current_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
           br_valid, br_target, mret_valid, mepc, trap_valid, trap_vec
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, current_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
           br_valid, br_target, mret_valid, mepc, trap_valid, trap_vec
  );

endinterface

// File: rtl/ifu_redirect_mux.sv
// Same-cycle redirect priority select: trap over mret over branch/jump.
module ifu_redirect_mux
  import ifu_fetch_ctrl_pkg::*;
(
  input  logic              br_valid,
  input  logic [XLEN-1:0]   br_target,
  input  logic              mret_valid,
  input  logic [XLEN-1:0]   mepc,
  input  logic              trap_valid,
  input  logic [XLEN-1:0]   trap_vec,
  output logic              redir_valid_c,
  output logic [XLEN-1:0]   redir_target_c,
  output redir_cause_e      redir_cause_c
);

  assign redir_valid_c = trap_valid | mret_valid | br_valid;

  // Lower-priority requests raised in the same cycle are simply dropped.
  always_comb begin
    redir_cause_c  = REDIR_NONE;
    redir_target_c = '0;
    if (trap_valid) begin
      redir_cause_c  = REDIR_TRAP;
      redir_target_c = trap_vec;
    end else if (mret_valid) begin
      redir_cause_c  = REDIR_MRET;
      redir_target_c = mepc;
    end else if (br_valid) begin
      redir_cause_c  = REDIR_BR;
      redir_target_c = br_target;
    end
  end

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues one imem request per PC, holds the returned
// instruction for decode and applies prioritised redirects, killing stale fetches.
module ifu_fetch_ctrl
  import ifu_fetch_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  ifu_fetch_ctrl_if.master   bus
);

  fetch_state_e     state;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  pend_pc;
  logic             pend;
  logic             kill;
  logic             req_valid;
  logic             inst_valid;
  fetch_inst_t      held;

  logic             redir_valid_c;
  logic [XLEN-1:0]  redir_target_c;
  redir_cause_e     redir_cause_c;

  ifu_redirect_mux u_redirect_mux (
    .br_valid       (bus.br_valid),
    .br_target      (bus.br_target),
    .mret_valid     (bus.mret_valid),
    .mepc           (bus.mepc),
    .trap_valid     (bus.trap_valid),
    .trap_vec       (bus.trap_vec),
    .redir_valid_c  (redir_valid_c),
    .redir_target_c (redir_target_c),
    .redir_cause_c  (redir_cause_c)
  );

  // Valid flag and cause encoding must always describe the same redirect.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (redir_valid_c == (redir_cause_c != REDIR_NONE));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_REQ;
      pc         <= PC_RST;
      pend_pc    <= '0;
      pend       <= 1'b0;
      kill       <= 1'b0;
      req_valid  <= 1'b1;
      inst_valid <= 1'b0;
      held       <= '0;
    end else begin
      case (state)
        // Address is frozen while the request stalls; a redirect waits in pend_pc.
        ST_REQ: begin
          if (bus.imem_req_ready) begin
            state     <= ST_WAIT;
            req_valid <= 1'b0;
            pend      <= 1'b0;
            if (redir_valid_c) begin
              pc   <= redir_target_c;
              kill <= 1'b1;
            end else if (pend) begin
              pc   <= pend_pc;
              kill <= 1'b1;
            end
          end else if (redir_valid_c) begin
            pend_pc <= redir_target_c;
            pend    <= 1'b1;
          end
        end

        ST_WAIT: begin
          if (redir_valid_c) begin
            pc <= redir_target_c;
            if (bus.imem_rsp_valid) begin
              kill      <= 1'b0;
              state     <= ST_REQ;
              req_valid <= 1'b1;
            end else begin
              kill <= 1'b1;
            end
          end else if (bus.imem_rsp_valid) begin
            if (kill) begin
              kill      <= 1'b0;
              state     <= ST_REQ;
              req_valid <= 1'b1;
            end else begin
              held       <= '{pc: pc, word: bus.imem_rsp_data};
              inst_valid <= 1'b1;
              state      <= ST_OUT;
            end
          end
        end

        // Redirect beats a same-cycle decode handshake; no pc+4 in that case.
        ST_OUT: begin
          if (redir_valid_c || bus.inst_ready) begin
            pc         <= redir_valid_c ? redir_target_c : next_seq_pc(pc);
            inst_valid <= 1'b0;
            state      <= ST_REQ;
            req_valid  <= 1'b1;
          end
        end

        default: begin
          state      <= ST_REQ;
          req_valid  <= 1'b1;
          inst_valid <= 1'b0;
          kill       <= 1'b0;
          pend       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc;
  assign bus.inst_valid     = inst_valid;
  assign bus.inst           = held.word;
  assign bus.inst_pc        = held.pc;
  assign bus.current_pc     = pc;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Bench for ifu_fetch_ctrl: directed scenarios followed by randomized traffic,
// checked against a transaction-level model of the delivered instruction stream.
module tb_ifu_fetch_ctrl;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic clk;
  logic rst;
  ifu_fetch_ctrl_if bus ();

  ifu_fetch_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } mreq_t;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          deliveries = 0;
  int          ready_mode = 1;
  int          inst_mode = 1;
  int          rsp_lat = 1;
  bit          lat_rand = 1'b0;

  mreq_t       mq[$];
  logic [63:0] req_log_addr[$];
  int          req_log_cyc[$];

  logic [63:0] exp_pc;
  bit          p_req_stall, p_inst_stall, p_redir, p_redir_pc;
  logic [63:0] p_addr, p_inst_pc, p_tgt;
  logic [31:0] p_inst;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_pc       = RST_PC;
    p_req_stall  = 1'b0;
    p_inst_stall = 1'b0;
    p_redir      = 1'b0;
    p_redir_pc   = 1'b0;
  endtask

  task automatic drive_env();
    case (ready_mode)
      0:       bus.imem_req_ready = 1'b0;
      1:       bus.imem_req_ready = 1'b1;
      default: bus.imem_req_ready = 1'($urandom_range(0, 1));
    endcase
    case (inst_mode)
      0:       bus.inst_ready = 1'b0;
      1:       bus.inst_ready = 1'b1;
      default: bus.inst_ready = 1'($urandom_range(0, 1));
    endcase
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(mq[0].addr);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
    end
  endtask

  // Stream-level rules: delivered instructions follow exp_pc, a redirect retargets it,
  // handshakes hold their payload, and one request at most is outstanding.
  task automatic observe();
    logic        redir;
    logic        req_stall;
    logic [63:0] tgt;
    redir = bus.trap_valid | bus.mret_valid | bus.br_valid;
    tgt   = bus.trap_valid ? bus.trap_vec : (bus.mret_valid ? bus.mepc : bus.br_target);

    if (p_req_stall) begin
      check("req_hold_valid", 64'(bus.imem_req_valid), 64'd1);
      check("req_hold_addr", bus.imem_req_addr, p_addr);
    end
    if (p_inst_stall) begin
      check("inst_hold_valid", 64'(bus.inst_valid), 64'd1);
      check("inst_hold_word", 64'(bus.inst), 64'(p_inst));
      check("inst_hold_pc", bus.inst_pc, p_inst_pc);
    end
    if (p_redir) begin
      check("drop_after_redir", 64'(bus.inst_valid), 64'd0);
      if (p_redir_pc) check("pc_after_redir", bus.current_pc, p_tgt);
    end
    if (bus.inst_valid) check("cur_pc_vs_inst_pc", bus.current_pc, bus.inst_pc);

    if (bus.inst_valid && bus.inst_ready && !redir) begin
      check("inst_pc", bus.inst_pc, exp_pc);
      check("inst_word", 64'(bus.inst), 64'(mem_word(exp_pc)));
      exp_pc = exp_pc + 64'd4;
      deliveries++;
    end
    if (redir) exp_pc = tgt;

    if (bus.imem_rsp_valid) void'(mq.pop_front());
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      check("one_inflight", 64'(mq.size()), 64'd0);
      mq.push_back('{addr: bus.imem_req_addr,
                     due:  cyc + (lat_rand ? int'($urandom_range(1, 3)) : rsp_lat)});
      req_log_addr.push_back(bus.imem_req_addr);
      req_log_cyc.push_back(cyc);
    end

    req_stall    = bus.imem_req_valid && !bus.imem_req_ready;
    p_req_stall  = req_stall;
    p_addr       = bus.imem_req_addr;
    p_inst_stall = bus.inst_valid && !bus.inst_ready && !redir;
    p_inst       = bus.inst;
    p_inst_pc    = bus.inst_pc;
    p_redir      = redir;
    p_redir_pc   = redir && !req_stall;
    p_tgt        = tgt;
  endtask

  task automatic cycle();
    drive_env();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_redir();
    bus.br_valid   = 1'b0;
    bus.mret_valid = 1'b0;
    bus.trap_valid = 1'b0;
  endtask

  task automatic run_until_req(input int max, input bit no_inst, output logic [63:0] a);
    int n;
    n = 0;
    a = '0;
    req_log_addr.delete();
    req_log_cyc.delete();
    while (req_log_addr.size() == 0 && n < max) begin
      cycle();
      n++;
      if (no_inst) check("no_inst_while_killed", 64'(bus.inst_valid), 64'd0);
    end
    check("req_within_budget", 64'(req_log_addr.size() > 0), 64'd1);
    if (req_log_addr.size() > 0) a = req_log_addr[0];
  endtask

  task automatic run_until_inst(input int max);
    int n;
    n = 0;
    while (!bus.inst_valid && n < max) begin
      cycle();
      n++;
    end
    check("inst_within_budget", 64'(bus.inst_valid), 64'd1);
  endtask

  logic [63:0] a;
  logic [63:0] held_pc;
  logic [31:0] held_word;
  int          start_del;

  initial begin
    rst = 1'b1;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.inst_ready     = 1'b0;
    bus.br_target      = '0;
    bus.mepc           = '0;
    bus.trap_vec       = '0;
    clear_redir();
    model_reset();

    // reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_req_valid", 64'(bus.imem_req_valid), 64'd1);
    check("rst_req_addr", bus.imem_req_addr, RST_PC);
    check("rst_inst_valid", 64'(bus.inst_valid), 64'd0);
    check("rst_inst", 64'(bus.inst), 64'd0);
    check("rst_inst_pc", bus.inst_pc, 64'd0);
    check("rst_current_pc", bus.current_pc, RST_PC);
    rst = 1'b0;

    // streaming fetch, 3 cycles per instruction
    ready_mode = 1; inst_mode = 1; rsp_lat = 1;
    req_log_addr.delete();
    req_log_cyc.delete();
    for (int i = 0; i < 8; i++) cycle();
    check("stream_req_count", 64'(req_log_addr.size() >= 3), 64'd1);
    if (req_log_addr.size() >= 3) begin
      check("stream_addr0", req_log_addr[0], 64'h8000_0000);
      check("stream_addr1", req_log_addr[1], 64'h8000_0004);
      check("stream_addr2", req_log_addr[2], 64'h8000_0008);
      check("stream_gap01", 64'(req_log_cyc[1] - req_log_cyc[0]), 64'd3);
      check("stream_gap12", 64'(req_log_cyc[2] - req_log_cyc[1]), 64'd3);
    end

    // decode back-pressure
    inst_mode = 0;
    run_until_inst(10);
    held_pc   = bus.inst_pc;
    held_word = bus.inst;
    check("bp_held_pc", held_pc, 64'h8000_0008);
    req_log_addr.delete();
    for (int i = 0; i < 5; i++) cycle();
    check("bp_no_request", 64'(req_log_addr.size()), 64'd0);
    check("bp_inst_stable", 64'(bus.inst), 64'(held_word));
    check("bp_inst_pc_stable", bus.inst_pc, held_pc);
    check("bp_pc_unchanged", bus.current_pc, held_pc);
    inst_mode = 1;
    run_until_req(10, 1'b0, a);
    check("bp_next_addr", a, 64'h8000_000C);

    // branch in WAIT kills the in-flight response
    rsp_lat = 2;
    run_until_inst(10);
    run_until_req(10, 1'b0, a);
    bus.br_valid  = 1'b1;
    bus.br_target = 64'h8000_0100;
    cycle();
    clear_redir();
    run_until_req(10, 1'b1, a);
    check("br_wait_next_addr", a, 64'h8000_0100);

    // trap + mret + branch together in OUT; trap wins, handshake ignored
    rsp_lat = 1;
    run_until_inst(10);
    bus.trap_valid = 1'b1; bus.trap_vec  = 64'h8000_0800;
    bus.mret_valid = 1'b1; bus.mepc      = 64'h8000_0400;
    bus.br_valid   = 1'b1; bus.br_target = 64'h8000_0200;
    cycle();
    clear_redir();
    check("prio_inst_dropped", 64'(bus.inst_valid), 64'd0);
    check("prio_current_pc", bus.current_pc, 64'h8000_0800);
    run_until_req(10, 1'b1, a);
    check("prio_next_addr", a, 64'h8000_0800);

    // redirect while the request is stalled
    ready_mode = 0;
    for (int i = 0; i < 4; i++) cycle();
    check("stall_req_valid", 64'(bus.imem_req_valid), 64'd1);
    check("stall_old_addr", bus.imem_req_addr, 64'h8000_0804);
    bus.br_valid  = 1'b1;
    bus.br_target = 64'h8000_0340;
    cycle();
    clear_redir();
    cycle();
    cycle();
    check("stall_addr_frozen", bus.imem_req_addr, 64'h8000_0804);
    check("stall_pc_frozen", bus.current_pc, 64'h8000_0804);
    ready_mode = 1;
    run_until_req(10, 1'b0, a);
    check("stall_accept_old", a, 64'h8000_0804);
    run_until_req(10, 1'b1, a);
    check("stall_pend_target", a, 64'h8000_0340);
    run_until_inst(10);
    check("stall_inst_pc", bus.inst_pc, 64'h8000_0340);

    // pc+4 wraps to zero
    bus.br_valid  = 1'b1;
    bus.br_target = 64'hFFFF_FFFF_FFFF_FFFC;
    cycle();
    clear_redir();
    run_until_req(10, 1'b0, a);
    check("wrap_top_addr", a, 64'hFFFF_FFFF_FFFF_FFFC);
    run_until_req(10, 1'b0, a);
    check("wrap_zero_addr", a, 64'h0);
    run_until_inst(10);
    check("wrap_inst_pc", bus.inst_pc, 64'h0);

    // async reset in WAIT
    rsp_lat = 3;
    run_until_req(10, 1'b0, a);
    #2;
    rst = 1'b1;
    #1;
    check("arst_req_valid", 64'(bus.imem_req_valid), 64'd1);
    check("arst_req_addr", bus.imem_req_addr, RST_PC);
    check("arst_current_pc", bus.current_pc, RST_PC);
    check("arst_inst_valid", 64'(bus.inst_valid), 64'd0);
    check("arst_inst_pc", bus.inst_pc, 64'd0);
    model_reset();
    bus.imem_rsp_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rsp_lat = 1;
    run_until_req(10, 1'b0, a);
    check("arst_first_addr", a, RST_PC);

    // randomized traffic
    ready_mode = 2; inst_mode = 2; lat_rand = 1'b1;
    start_del = deliveries;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        bus.br_valid   = 1'($urandom_range(0, 1));
        bus.mret_valid = 1'($urandom_range(0, 1));
        bus.trap_valid = 1'($urandom_range(0, 1));
        bus.br_target  = RST_PC + 64'($urandom_range(0, 4095));
        bus.mepc       = {32'($urandom), 32'($urandom)};
        bus.trap_vec   = RST_PC + 64'($urandom_range(0, 255) * 4);
      end
      cycle();
      clear_redir();
    end
    check("random_progress", 64'(deliveries - start_del >= 50), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
